// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised general-purpose register file.
//   N combinational read ports, one write port, optional write-to-read bypass.
//   Register 0 reads as zero. STATUS_REG holds sticky, write-1-to-clear
//   flags that capture rising edges of asynchronous peripheral lines.
//   A sweep-clear sequencer zeroes registers 1..DEPTH-1, one per cycle.
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   rd_addr/rd_data   packed read ports, port k at slice k
//   wr_en/addr/data   single write port
//   status_in         asynchronous peripheral event lines
//   clr_req           request a sweep-clear of all registers
//   clr_busy          sweep-clear in progress
//   irq_pending       OR of the sticky status bits
module regfile_multiport #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned BYPASS     = 1,
    parameter int unsigned STATUS_REG = 27,
    parameter int unsigned STATUS_W   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [STATUS_W-1:0]        status_in,
    input  logic                       clr_req,
    output logic                       clr_busy,
    output logic                       irq_pending
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] STICKY_MASK = ~({DATA_W{1'b1}} << STATUS_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(STATUS_REG);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   cnt, cnt_next;
    logic [DATA_W-1:0]   regs [DEPTH];
    logic [STATUS_W-1:0] s1, s2, s3;
    logic [STATUS_W-1:0] rise;
    logic [DATA_W-1:0]   status_next;
    logic                wr_ok;
    logic                sweep_hit;
    logic [ADDR_W-1:0]   ra;

    assign wr_ok     = wr_en && (wr_addr != '0) && (state == IDLE);
    assign sweep_hit = (state == CLEAR);
    assign rise      = s2 & ~s3;

    // Sweep-clear sequencer: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Sweep-clear sequencer: next state; terminates on the last index, not on wrap
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    cnt_next   = ADDR_W'(1);
                end
            end
            CLEAR: begin
                cnt_next = cnt + ADDR_W'(1);
                if (cnt == LAST_ADDR) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Two-flop synchroniser plus edge flop per status line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= status_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Next status word: sweep or W1C write first, then a rise sets (set wins)
    always_comb begin
        status_next = regs[STATUS_REG];
        if (sweep_hit && (cnt == STATUS_ADDR)) begin
            status_next = '0;
        end else if (wr_ok && (wr_addr == STATUS_ADDR)) begin
            status_next = (wr_data & ~STICKY_MASK)
                        | (regs[STATUS_REG] & ~wr_data & STICKY_MASK);
        end
        status_next = status_next | DATA_W'(rise);
    end

    // Register array
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (i == STATUS_REG) begin
                    regs[i] <= status_next;
                end else if (sweep_hit && (cnt == ADDR_W'(i))) begin
                    regs[i] <= '0;
                end else if (wr_ok && (wr_addr == ADDR_W'(i))) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    // Status outputs, registered alongside the state they summarise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_busy    <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            clr_busy    <= (state_next == CLEAR);
            irq_pending <= |status_next[STATUS_W-1:0];
        end
    end

    // Combinational read ports with optional same-cycle forwarding
    always_comb begin
        rd_data = '0;
        ra      = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            ra = rd_addr[k*ADDR_W +: ADDR_W];
            if (ra == '0) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
            end else if ((BYPASS != 0) && wr_ok && (wr_addr == ra)) begin
                rd_data[k*DATA_W +: DATA_W] = wr_data;
            end else begin
                rd_data[k*DATA_W +: DATA_W] = regs[ra];
            end
        end
    end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised general-purpose register file for the MIPS core.
- Replaces the fixed 32x32, 2-read-port register file.
- Supports N combinational read ports and one write port, with optional write-to-read bypass.
- Adds a status register whose low bits capture rising edges of asynchronous peripheral lines (UART, timer, ...) as sticky software-clearable flags, plus a hardware sweep-clear sequencer.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers. Register 0 is hardwired to zero.
- NUM_RD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads return stored value only.
- STATUS_REG, 27, index of the status register (1..DEPTH-1).
- STATUS_W, 2, number of sticky status bits, at bits [STATUS_W-1:0] of STATUS_REG (1..DATA_W).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses slice [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data; port k uses slice [k*DATA_W +: DATA_W].
- wr_en  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- status_in  in  STATUS_W  asynchronous peripheral event lines.
- clr_req  in  1  single-cycle request to zero all registers.
- clr_busy  out  1  sweep-clear in progress.
- irq_pending  out  1  OR of the sticky status bits.

Behaviour:
- Reset (reset=0, async), all of the following clear to 0:
  - all registers,
  - synchroniser and edge flops,
  - the FSM, which goes to IDLE,
  - clr_busy and irq_pending.
- Reads are combinational:
  - rd_addr=0 returns 0.
  - Otherwise the stored value is returned.
  - If BYPASS=1, wr_en=1, wr_addr==rd_addr, wr_addr!=0 and FSM=IDLE, then rd_data=wr_data in the same cycle.
  - Bypass for STATUS_REG returns wr_data unmodified; W1C semantics are not applied to the forwarded value.
- Writes: on a rising clk edge with wr_en=1, wr_addr!=0 and FSM=IDLE, register[wr_addr] takes wr_data. Writes to address 0 are ignored.
- Status register writes:
  - Bits [DATA_W-1:STATUS_W] are written normally.
  - Bits [STATUS_W-1:0] are write-1-to-clear: a 1 in wr_data clears the bit, a 0 leaves it unchanged.
- Status capture, per bit i:
  - status_in[i] passes through a 2-flop synchroniser (s1, s2), then an edge flop (s3 <= s2).
  - Rise = s2 & ~s3 sets sticky bit i.
  - Latency: status_in sampled high at edge 1 → sticky bit set at edge 3, visible on rd_data after edge 3.
  - Because s3 resets to 0, a line already high at reset release is captured as one edge.
  - If a rise and a W1C or sweep-clear hit the same bit in the same cycle, set wins.
- irq_pending = |sticky bits, derived from register state with no extra delay.
- Sweep-clear FSM:
  - IDLE: clr_req=1 → go to CLEAR, load cnt=1, assert clr_busy from the next cycle.
  - CLEAR: each cycle register[cnt] <= 0 (sticky set-wins rule still applies) and cnt increments. The cycle with cnt==DEPTH-1 clears the last register; the next state is IDLE.
  - clr_busy is high for exactly DEPTH-1 cycles.
  - While in CLEAR:
    - wr_en is ignored and the write is dropped.
    - clr_req is ignored.
    - Bypass is disabled.
    - Reads return current array contents, partially cleared.
  - Status synchronisers keep running during CLEAR.
  - Asserting reset mid-sweep aborts the sweep immediately: FSM goes to IDLE and all registers are 0.
- Wrap-around: cnt is ADDR_W wide; termination is on cnt==DEPTH-1, not on wrap to 0.

Test Plan:
- Reset, then write 0xDEADBEEF to r5 and read it on both ports → both return 0xDEADBEEF; write 0x1234 to r0 → reads of r0 return 0.
- BYPASS=1: same cycle wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5, rd_addr0=7 → rd_data0=0xA5A5A5A5 in that cycle while the stored r7 still holds the old value; BYPASS=0 → old value.
- Pulse status_in[0] high for 1 clk → r27 bit0=1 exactly 3 edges later and irq_pending=1. Write r27 with 0xFFFF0001 → r27=0xFFFF0000 and irq_pending=0. Write 0x00000000 to r27 while a bit is set → the bit is retained.
- Rising edge of status_in[1] coincides with a W1C write of bit1 → bit1 remains 1.
- Fill r1..r31 with nonzero values, pulse clr_req → clr_busy high 31 cycles and all registers 0 afterwards. A wr_en to r3 mid-sweep is dropped (r3=0 at end). A second clr_req mid-sweep does not extend clr_busy.
- Assert reset at sweep cycle 10 → clr_busy=0 immediately and all reads return 0. status_in held high across reset release → sticky bit sets 3 edges after release.
